// File: rtl/parity_check_pkg.sv
// Shared constants and helpers for the nibble parity checker.
// Imported by the interface, the syndrome generator and the top level.
package parity_check_pkg;

  localparam bit PARITY_EVEN   = 1'b0;
  localparam bit PARITY_ODD    = 1'b1;
  localparam int CNT_W_DEFAULT = 8;

  // Increment a counter held in the low w bits of v, holding at all-ones.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] max_v;
    max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (v == max_v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/parity_check_if.sv
// Receive-side nibble/parity bundle plus the checker's status outputs.
// The master modport is the link side; the slave modport is the checker.
interface parity_check_if
  import parity_check_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
);

  logic             a;
  logic             b;
  logic             c;
  logic             d;
  logic             p;
  logic             clr;
  logic             pec;
  logic             pec_sticky;
  logic [CNT_W-1:0] err_cnt;

  modport master (
    output a, b, c, d, p, clr,
    input  pec, pec_sticky, err_cnt
  );

  modport slave (
    input  a, b, c, d, p, clr,
    output pec, pec_sticky, err_cnt
  );

endinterface

// File: rtl/parity_check_gen.sv
// Combinational parity syndrome: s = 1 flags a parity error on the nibble.
// The polarity bit folds odd parity into the same XOR reduction.
module parity_gen
  import parity_check_pkg::*;
#(
  parameter bit ODD_PARITY = PARITY_EVEN
) (
  input  logic [3:0] data,
  input  logic       p,
  output logic       s
);

  assign s = (^data) ^ p ^ ODD_PARITY;

endmodule

// File: rtl/parity_check.sv
// Registered parity checker: per-cycle error flag, sticky error flag and a
// saturating error counter, with synchronous clear taking priority.
module parity_check
  import parity_check_pkg::*;
#(
  parameter bit ODD_PARITY = PARITY_EVEN,
  parameter int CNT_W      = CNT_W_DEFAULT
) (
  input logic           clk,
  input logic           rst_n,
  parity_check_if.slave bus
);

  logic             s;
  logic             pec;
  logic             pec_sticky;
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] err_cnt_nxt;

  parity_gen #(
    .ODD_PARITY (ODD_PARITY)
  ) u_gen (
    .data ({bus.a, bus.b, bus.c, bus.d}),
    .p    (bus.p),
    .s    (s)
  );

  always_comb begin
    // NOTE: default first so every path assigns err_cnt_nxt and no latch is inferred.
    err_cnt_nxt = err_cnt;
    if (s) begin
      err_cnt_nxt = CNT_W'(sat_inc(32'(err_cnt), CNT_W));
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pec        <= 1'b0;
      pec_sticky <= 1'b0;
      err_cnt    <= '0;
    end else begin
      pec <= s;
      if (bus.clr) begin
        pec_sticky <= 1'b0;
        err_cnt    <= '0;
      end else begin
        pec_sticky <= pec_sticky | s;
        err_cnt    <= err_cnt_nxt;
      end
    end
  end

  assign bus.pec        = pec;
  assign bus.pec_sticky = pec_sticky;
  assign bus.err_cnt    = err_cnt;

endmodule

// File: tb/tb_parity_check.sv
// Directed bench for parity_check: even sweep, odd polarity, saturation,
// clear precedence, asynchronous reset and sticky hold.
module tb_parity_check;
  import parity_check_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  parity_check_if #(.CNT_W(8)) e_if ();
  parity_check_if #(.CNT_W(8)) o_if ();
  parity_check_if #(.CNT_W(3)) s_if ();

  parity_check #(.ODD_PARITY(PARITY_EVEN), .CNT_W(8)) u_even (
    .clk (clk), .rst_n (rst_n), .bus (e_if)
  );
  parity_check #(.ODD_PARITY(PARITY_ODD), .CNT_W(8)) u_odd (
    .clk (clk), .rst_n (rst_n), .bus (o_if)
  );
  parity_check #(.ODD_PARITY(PARITY_EVEN), .CNT_W(3)) u_sat (
    .clk (clk), .rst_n (rst_n), .bus (s_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Vector order is {a,b,c,d,p}.
  task automatic drive_e(input logic [4:0] v, input logic cl);
    {e_if.a, e_if.b, e_if.c, e_if.d, e_if.p} = v;
    e_if.clr = cl;
  endtask

  task automatic drive_o(input logic [4:0] v, input logic cl);
    {o_if.a, o_if.b, o_if.c, o_if.d, o_if.p} = v;
    o_if.clr = cl;
  endtask

  task automatic drive_s(input logic [4:0] v, input logic cl);
    {s_if.a, s_if.b, s_if.c, s_if.d, s_if.p} = v;
    s_if.clr = cl;
  endtask

  // Advance one edge and land 1 time unit after it, clear of the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_cnt;
    logic [4:0] v;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    drive_e(5'b00000, 1'b0);
    drive_o(5'b00000, 1'b0);
    drive_s(5'b00000, 1'b0);

    // Reset state
    #12;
    check("reset_pec",        32'(e_if.pec),        32'd0);
    check("reset_sticky",     32'(e_if.pec_sticky), 32'd0);
    check("reset_cnt",        32'(e_if.err_cnt),    32'd0);
    check("reset_odd_pec",    32'(o_if.pec),        32'd0);
    #2 rst_n = 1'b1;

    // Even sweep of all 32 input combinations
    exp_cnt = 0;
    for (int i = 0; i < 32; i++) begin
      v = 5'(i);
      drive_e(v, 1'b0);
      step();
      exp_cnt += int'(^v);
      check($sformatf("sweep_pec_%0d", i), 32'(e_if.pec),     32'(^v));
      check($sformatf("sweep_cnt_%0d", i), 32'(e_if.err_cnt), 32'(exp_cnt));
    end
    check("sweep_final_cnt",    32'(e_if.err_cnt),    32'd16);
    check("sweep_final_sticky", 32'(e_if.pec_sticky), 32'd1);

    // Odd polarity
    drive_o(5'b10000, 1'b0);
    step();
    check("odd_10000_pec", 32'(o_if.pec), 32'd0);
    drive_o(5'b00000, 1'b0);
    step();
    check("odd_00000_pec", 32'(o_if.pec), 32'd1);

    // Saturation with a 3-bit counter
    drive_s(5'b00000, 1'b1);
    step();
    check("sat_clr_cnt", 32'(s_if.err_cnt), 32'd0);
    drive_s(5'b10000, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      step();
      check($sformatf("sat_cnt_%0d", k), 32'(s_if.err_cnt), (k < 7) ? 32'(k) : 32'd7);
      check($sformatf("sat_pec_%0d", k), 32'(s_if.pec),     32'd1);
    end
    check("sat_sticky", 32'(s_if.pec_sticky), 32'd1);

    // Clear precedence over a simultaneous error
    drive_e(5'b00000, 1'b1);
    step();
    check("clr_pre_cnt", 32'(e_if.err_cnt), 32'd0);
    drive_e(5'b10000, 1'b0);
    repeat (5) step();
    check("clr_cnt5",    32'(e_if.err_cnt),    32'd5);
    check("clr_sticky1", 32'(e_if.pec_sticky), 32'd1);
    drive_e(5'b10000, 1'b1);
    step();
    check("clr_win_cnt",    32'(e_if.err_cnt),    32'd0);
    check("clr_win_sticky", 32'(e_if.pec_sticky), 32'd0);
    check("clr_win_pec",    32'(e_if.pec),        32'd1);
    drive_e(5'b10000, 1'b0);
    step();
    check("clr_next_cnt", 32'(e_if.err_cnt), 32'd1);

    // Asynchronous reset between edges
    drive_e(5'b00000, 1'b1);
    step();
    drive_e(5'b01000, 1'b0);
    repeat (3) step();
    check("arst_pre_cnt", 32'(e_if.err_cnt), 32'd3);
    drive_e(5'b00000, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_pec",     32'(e_if.pec),        32'd0);
    check("arst_sticky",  32'(e_if.pec_sticky), 32'd0);
    check("arst_cnt",     32'(e_if.err_cnt),    32'd0);
    check("arst_sat_cnt", 32'(s_if.err_cnt),    32'd0);
    #2 rst_n = 1'b1;
    step();
    check("arst_rel_pec", 32'(e_if.pec),     32'd0);
    check("arst_rel_cnt", 32'(e_if.err_cnt), 32'd0);
    step();
    check("arst_rel_cnt2", 32'(e_if.err_cnt), 32'd0);

    // Sticky hold across clean cycles
    drive_e(5'b00010, 1'b0);
    step();
    check("hold_err_pec", 32'(e_if.pec),     32'd1);
    check("hold_err_cnt", 32'(e_if.err_cnt), 32'd1);
    drive_e(5'b11000, 1'b0);
    for (int k = 0; k < 20; k++) begin
      step();
      check($sformatf("hold_pec_%0d", k), 32'(e_if.pec), 32'd0);
    end
    check("hold_sticky", 32'(e_if.pec_sticky), 32'd1);
    check("hold_cnt",    32'(e_if.err_cnt),    32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/parity_check.md
# parity_check

Single-cycle registered parity checker for a 4-bit data nibble (`a`..`d`) protected by one parity bit (`p`). Computes the error flag each clock, registers it, and keeps a sticky error flag and a saturating error counter for status reporting. Sits at the receive side of a nibble-wide link or storage read path, between the data capture registers and the status/interrupt logic.

## Interface
Parameters:
- `ODD_PARITY`, default 0: 0 selects even parity, where a, b, c, d and p together hold an even number of ones; 1 selects odd parity.
- `CNT_W`, default 8: width of the error counter, legal range 1..32.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `a`, `b`, `c`, `d`  in  1 each  data bits. Synchronous to `clk`.
- `p`  in  1  received parity bit.
- `clr`  in  1  synchronous clear of `pec_sticky` and `err_cnt`.
- `pec`  out  1  registered parity-error flag for the previous cycle's inputs.
- `pec_sticky`  out  1  set on any error; held until `clr` or reset.
- `err_cnt`  out  CNT_W  saturating count of cycles with an error.

## Operation
- Combinational syndrome `s = a ^ b ^ c ^ d ^ p ^ ODD_PARITY`.
- `s = 1` means a parity error.
- Registered outputs:
  - `pec <= s` every cycle, unconditionally.
  - `pec_sticky <= clr ? 0 : (pec_sticky | s)`.
  - `err_cnt <= clr ? 0 : ((s && err_cnt != all-ones) ? err_cnt + 1 : err_cnt)`.
- Counting is level-based: each clock with `s = 1` counts once. A persistent error counts every cycle.
- Saturation: at all-ones, `err_cnt` holds its value, even with further errors.
- If `clr` and `s = 1` arrive in the same cycle, `clr` wins: sticky = 0 and count = 0. The error is still reflected in `pec`.
- No internal state other than `pec`, `pec_sticky` and `err_cnt`.

## Timing
- Reset: asserting `rst_n = 0` immediately forces `pec = 0`, `pec_sticky = 0`, `err_cnt = 0`, independent of `clk`.
- Reset release is synchronous to `clk`. The first update occurs at the first rising edge with `rst_n = 1`.
- Reset mid-operation discards all counts, with no partial update.
- Latency: inputs sampled at edge N appear on `pec`, `pec_sticky` and `err_cnt` after edge N.
- One-cycle latency, full throughput, no handshake.
- Inputs must meet setup/hold to `clk`. Asynchronous sources must be synchronized upstream.

## Structure
- Package `parity_check_pkg`:
  - `PARITY_EVEN = 0` and `PARITY_ODD = 1` constants.
  - Default `CNT_W` constant.
  - Saturating-increment function.
- Sub-module `parity_gen`: purely combinational XOR reduction of the data bits plus the parity bit plus the polarity parameter. It outputs `s`.
- The top level holds the three registers and the saturation/clear logic.

## Test plan
- Even parity, sweep all 32 combinations of {a,b,c,d,p} from 00000 upward. Required: `pec` equals the XOR of the five bits one cycle later; 16 cycles flag an error. With `CNT_W = 8`, `err_cnt = 16` and `pec_sticky = 1` at the end.
- `ODD_PARITY = 1`:
  - {a,b,c,d,p} = 1,0,0,0,0 gives `pec = 0`.
  - {a,b,c,d,p} = 0,0,0,0,0 gives `pec = 1`.
- Hold error 1,0,0,0,0 (even) with `CNT_W = 3` for 10 cycles. Required: `err_cnt` runs 1..7, then stays at 7; `pec` stays 1.
- Clear precedence: `err_cnt = 5`, `pec_sticky = 1`. Assert `clr` together with an erroneous input. Required after the edge: `err_cnt = 0`, `pec_sticky = 0`, `pec = 1`. The next error cycle makes `err_cnt = 1`.
- Async reset: with `err_cnt = 3`, drop `rst_n` between clock edges. Required: all outputs go to 0 without a clock edge. Release, apply 0,0,0,0,0 (even). Required: `pec = 0` and count stays 0.
- Sticky hold: one error cycle followed by 20 clean cycles. Required: `pec` returns to 0 after one cycle; `pec_sticky` stays 1; `err_cnt = 1`.
